ccr_update: RTL and testbench



---
 rtl/m68000_ccr_pkg.sv | 54 +++++
 rtl/ccr_flag_calc.sv | 100 ++++++++++
 rtl/ccr_update.sv | 91 +++++++++
 tb/tb_ccr_update.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/m68000_ccr_pkg.sv
// Shared codes for the m68000 condition-code path: flag classes, operand sizes,
// immediate CCR write ops, CCR bit positions and the writable-bit mask.
package m68000_ccr_pkg;

   typedef enum logic [3:0] {
      FOP_NONE   = 4'd0,
      FOP_ADD    = 4'd1,
      FOP_SUB    = 4'd2,
      FOP_CMP    = 4'd3,
      FOP_ADDX   = 4'd4,
      FOP_SUBX   = 4'd5,
      FOP_LOGIC  = 4'd6,
      FOP_SHIFT  = 4'd7,
      FOP_ROTATE = 4'd8,
      FOP_BCD    = 4'd9
   } flag_op_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_WORD = 2'b01,
      SZ_LONG = 2'b10,
      SZ_LNG2 = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      WOP_MOVE = 2'b00,
      WOP_AND  = 2'b01,
      WOP_OR   = 2'b10,
      WOP_EOR  = 2'b11
   } ccr_wop_e;

   localparam int CCR_C = 0;
   localparam int CCR_V = 1;
   localparam int CCR_Z = 2;
   localparam int CCR_N = 3;
   localparam int CCR_X = 4;

   localparam logic [7:0] CCR_MASK = 8'h1F;

   // Immediate MOVE/ANDI/ORI/EORI to CCR; upper three bits never survive.
   function automatic logic [7:0] applyWop(input logic [1:0] wop,
                                           input logic [7:0] cur,
                                           input logic [7:0] din);
      logic [7:0] v;
      case (wop)
         WOP_MOVE: v = din;
         WOP_AND:  v = cur & din;
         WOP_OR:   v = cur | din;
         default:  v = cur ^ din;
      endcase
      return v & CCR_MASK;
   endfunction

endpackage

// File: rtl/ccr_flag_calc.sv
// Combinational X/N/Z/V/C generator from registered ALU fields and current CCR.
// Decimal (flag_op 9) handling exists only when CCR_BCD_EN is defined.
module ccr_flag_calc
   import m68000_ccr_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_src,
   input  logic [31:0] i_dst,
   input  logic [31:0] i_res,
   input  logic        i_shiftC,
   input  logic        i_shiftV,
   input  logic        i_shiftCnt0,
`ifdef CCR_BCD_EN
   input  logic        i_bcdC,
`endif
   input  logic [4:0]  i_ccr,
   output logic [4:0]  o_flags
);

   logic w_sm, w_dm, w_rm, w_zero;
   logic w_addC, w_addV, w_subC, w_subV;

   always_comb begin
      w_sm   = i_src[31];
      w_dm   = i_dst[31];
      w_rm   = i_res[31];
      w_zero = (i_res == 32'h0);
      case (i_size)
         SZ_BYTE: begin
            w_sm   = i_src[7];
            w_dm   = i_dst[7];
            w_rm   = i_res[7];
            w_zero = (i_res[7:0] == 8'h0);
         end
         SZ_WORD: begin
            w_sm   = i_src[15];
            w_dm   = i_dst[15];
            w_rm   = i_res[15];
            w_zero = (i_res[15:0] == 16'h0);
         end
         default: ;
      endcase
   end

   assign w_addC = (w_sm & w_dm) | (~w_rm & w_dm) | (w_sm & ~w_rm);
   assign w_addV = (w_sm & w_dm & ~w_rm) | (~w_sm & ~w_dm & w_rm);
   assign w_subC = (w_sm & ~w_dm) | (w_rm & ~w_dm) | (w_sm & w_rm);
   assign w_subV = (~w_sm & w_dm & ~w_rm) | (w_sm & ~w_dm & w_rm);

   // Extended ops keep Z sticky: it can only be cleared, never set, so
   // multi-precision chains test zero across every word.
   always_comb begin
      o_flags = i_ccr;
      case (i_op)
         FOP_ADD, FOP_ADDX: begin
            o_flags[CCR_X] = w_addC;
            o_flags[CCR_C] = w_addC;
            o_flags[CCR_V] = w_addV;
            o_flags[CCR_N] = w_rm;
            o_flags[CCR_Z] = (i_op == FOP_ADDX) ? (i_ccr[CCR_Z] & w_zero) : w_zero;
         end
         FOP_SUB, FOP_SUBX, FOP_CMP: begin
            if (i_op != FOP_CMP) o_flags[CCR_X] = w_subC;
            o_flags[CCR_C] = w_subC;
            o_flags[CCR_V] = w_subV;
            o_flags[CCR_N] = w_rm;
            o_flags[CCR_Z] = (i_op == FOP_SUBX) ? (i_ccr[CCR_Z] & w_zero) : w_zero;
         end
         FOP_LOGIC: begin
            o_flags[CCR_N] = w_rm;
            o_flags[CCR_Z] = w_zero;
            o_flags[CCR_V] = 1'b0;
            o_flags[CCR_C] = 1'b0;
         end
         FOP_SHIFT: begin
            o_flags[CCR_N] = w_rm;
            o_flags[CCR_Z] = w_zero;
            o_flags[CCR_V] = i_shiftV;
            o_flags[CCR_C] = i_shiftCnt0 ? 1'b0 : i_shiftC;
            if (!i_shiftCnt0) o_flags[CCR_X] = i_shiftC;
         end
         FOP_ROTATE: begin
            o_flags[CCR_N] = w_rm;
            o_flags[CCR_Z] = w_zero;
            o_flags[CCR_V] = 1'b0;
            o_flags[CCR_C] = i_shiftCnt0 ? 1'b0 : i_shiftC;
         end
`ifdef CCR_BCD_EN
         FOP_BCD: begin
            o_flags[CCR_X] = i_bcdC;
            o_flags[CCR_C] = i_bcdC;
            o_flags[CCR_Z] = i_ccr[CCR_Z] & w_zero;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/ccr_update.sv
// Two-stage CCR producer: operand capture, then flag commit merged with
// immediate CCR writes. Optional decimal flags via CCR_BCD_EN.
module ccr_update
   import m68000_ccr_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        upd,
   input  logic [3:0]  flag_op,
   input  logic [1:0]  size,
   input  logic [31:0] src,
   input  logic [31:0] dst,
   input  logic [31:0] res,
   input  logic        shift_c,
   input  logic        shift_v,
   input  logic        shift_cnt0,
   input  logic        bcd_c,
   input  logic        ccr_wr,
   input  logic [1:0]  ccr_wop,
   input  logic [7:0]  ccr_din,
   output logic [7:0]  ccr,
   output logic        pending
);

   logic        r_valid;
   logic [3:0]  r_op;
   logic [1:0]  r_size;
   logic [31:0] r_src, r_dst, r_res;
   logic        r_shiftC, r_shiftV, r_shiftCnt0;
   logic [7:0]  r_ccr;
   logic [4:0]  w_flags;
   logic [7:0]  w_committed, w_ccrNext;

`ifdef CCR_BCD_EN
   logic        r_bcdC;
`else
   logic        w_unusedBcd;
   assign w_unusedBcd = bcd_c;
`endif

   // Stage-1 payload needs no reset: it is only consumed when r_valid is set.
   always_ff @(posedge clk) begin
      if (upd) begin
         r_op        <= flag_op;
         r_size      <= size;
         r_src       <= src;
         r_dst       <= dst;
         r_res       <= res;
         r_shiftC    <= shift_c;
         r_shiftV    <= shift_v;
         r_shiftCnt0 <= shift_cnt0;
`ifdef CCR_BCD_EN
         r_bcdC      <= bcd_c;
`endif
      end
   end

   ccr_flag_calc u_calc (
      .i_op        (r_op),
      .i_size      (r_size),
      .i_src       (r_src),
      .i_dst       (r_dst),
      .i_res       (r_res),
      .i_shiftC    (r_shiftC),
      .i_shiftV    (r_shiftV),
      .i_shiftCnt0 (r_shiftCnt0),
`ifdef CCR_BCD_EN
      .i_bcdC      (r_bcdC),
`endif
      .i_ccr       (r_ccr[4:0]),
      .o_flags     (w_flags)
   );

   // An immediate write on a commit edge operates on the just-committed flags.
   assign w_committed = r_valid ? {3'b000, w_flags} : r_ccr;
   assign w_ccrNext   = ccr_wr ? applyWop(ccr_wop, w_committed, ccr_din) : w_committed;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_ccr   <= 8'h00;
      end else begin
         r_valid <= upd;
         r_ccr   <= w_ccrNext;
      end
   end

   assign ccr     = r_ccr;
   assign pending = r_valid;

endmodule

// File: tb/tb_ccr_update.sv
// Directed-vector bench for ccr_update: a driver queues hand-computed expected
// outputs per cycle and an independent monitor pops and compares them.
module tb_ccr_update;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        upd = 1'b0;
   logic [3:0]  flag_op = 4'd0;
   logic [1:0]  size = 2'd0;
   logic [31:0] src = 32'h0, dst = 32'h0, res = 32'h0;
   logic        shift_c = 1'b0, shift_v = 1'b0, shift_cnt0 = 1'b0, bcd_c = 1'b0;
   logic        ccr_wr = 1'b0;
   logic [1:0]  ccr_wop = 2'd0;
   logic [7:0]  ccr_din = 8'h0;
   logic [7:0]  ccr;
   logic        pending;

   ccr_update dut (
      .clk(clk), .rst(rst), .upd(upd), .flag_op(flag_op), .size(size),
      .src(src), .dst(dst), .res(res), .shift_c(shift_c), .shift_v(shift_v),
      .shift_cnt0(shift_cnt0), .bcd_c(bcd_c), .ccr_wr(ccr_wr),
      .ccr_wop(ccr_wop), .ccr_din(ccr_din), .ccr(ccr), .pending(pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] expCcr;
      logic       expPend;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   // Staged inputs for the next cycle; cleared back to idle after each drive.
   logic        nRst, nUpd, nShC, nShV, nCnt0, nBcd, nWr;
   logic [3:0]  nOp;
   logic [1:0]  nSize, nWop;
   logic [31:0] nSrc, nDst, nRes;
   logic [7:0]  nDin;

   task automatic clearStim();
      nRst = 0; nUpd = 0; nOp = 0; nSize = 0; nSrc = 0; nDst = 0; nRes = 0;
      nShC = 0; nShV = 0; nCnt0 = 0; nBcd = 0; nWr = 0; nWop = 0; nDin = 0;
   endtask

   task automatic setUpd(input logic [3:0] op, input logic [1:0] sz,
                         input logic [31:0] s, input logic [31:0] d, input logic [31:0] r);
      nUpd = 1; nOp = op; nSize = sz; nSrc = s; nDst = d; nRes = r;
   endtask

   task automatic setShift(input logic c, input logic v, input logic cnt0);
      nShC = c; nShV = v; nCnt0 = cnt0;
   endtask

   task automatic setWr(input logic [1:0] wop, input logic [8-1:0] din);
      nWr = 1; nWop = wop; nDin = din;
   endtask

   // Drive staged inputs for the coming edge and queue the outputs due after it.
   task automatic applyStimulus(input string name, input logic [7:0] expCcr, input logic expPend);
      exp_t e;
      @(negedge clk);
      rst = nRst; upd = nUpd; flag_op = nOp; size = nSize; src = nSrc; dst = nDst;
      res = nRes; shift_c = nShC; shift_v = nShV; shift_cnt0 = nCnt0; bcd_c = nBcd;
      ccr_wr = nWr; ccr_wop = nWop; ccr_din = nDin;
      e.name = name; e.expCcr = expCcr; e.expPend = expPend;
      sb.push_back(e);
      clearStim();
   endtask

   task automatic checkOutput(input exp_t e);
      checks++;
      if (ccr !== e.expCcr)
         $display("[TB] FAIL %s ccr: got %h expected %h", e.name, ccr, e.expCcr);
      else passed++;
      checks++;
      if (pending !== e.expPend)
         $display("[TB] FAIL %s pending: got %b expected %b", e.name, pending, e.expPend);
      else passed++;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin : driver
      clearStim();
      nRst = 1; applyStimulus("reset", 8'h00, 1'b0);
      applyStimulus("idle", 8'h00, 1'b0);

      setUpd(4'd1, 2'b00, 32'h7F, 32'h01, 32'h80);
      applyStimulus("addB_pend", 8'h00, 1'b1);
      applyStimulus("addB_commit", 8'h0A, 1'b0);
      applyStimulus("addB_hold", 8'h0A, 1'b0);

      setUpd(4'd2, 2'b10, 32'h1, 32'h0, 32'hFFFF_FFFF);
      applyStimulus("subL_pend", 8'h0A, 1'b1);
      setUpd(4'd3, 2'b10, 32'h5, 32'h5, 32'h0);
      applyStimulus("subL_commit", 8'h19, 1'b1);
      applyStimulus("cmp_commit", 8'h14, 1'b0);

      setUpd(4'd4, 2'b01, 32'h0, 32'h0, 32'hABCD_0000);
      applyStimulus("addx_z_pend", 8'h14, 1'b1);
      setUpd(4'd4, 2'b01, 32'h0, 32'h1, 32'h0001);
      applyStimulus("addx_z_kept", 8'h04, 1'b1);
      setUpd(4'd4, 2'b01, 32'h0, 32'h0, 32'h0);
      applyStimulus("addx_z_clr", 8'h00, 1'b1);
      applyStimulus("addx_z_sticky", 8'h00, 1'b0);

      setWr(2'b00, 8'h11);
      applyStimulus("move11", 8'h11, 1'b0);
      setUpd(4'd7, 2'b00, 32'h0, 32'h0, 32'h5A80); setShift(1, 1, 1);
      applyStimulus("shift_cnt0_pend", 8'h11, 1'b1);
      setUpd(4'd8, 2'b10, 32'h0, 32'h0, 32'h0); setShift(1, 1, 0);
      applyStimulus("shift_cnt0", 8'h1A, 1'b1);
      setUpd(4'd7, 2'b01, 32'h0, 32'h0, 32'h8000_0000); setShift(0, 0, 0);
      applyStimulus("rotate_L", 8'h15, 1'b1);
      applyStimulus("shift_word", 8'h04, 1'b0);

      setWr(2'b00, 8'hFF); applyStimulus("imm_move", 8'h1F, 1'b0);
      setWr(2'b01, 8'h04); applyStimulus("imm_and", 8'h04, 1'b0);
      setWr(2'b11, 8'h05); applyStimulus("imm_eor", 8'h01, 1'b0);
      setUpd(4'd6, 2'b10, 32'h0, 32'h0, 32'h0);
      applyStimulus("logic_pend", 8'h01, 1'b1);
      setWr(2'b10, 8'h01);
      applyStimulus("collide_or", 8'h05, 1'b0);
      applyStimulus("collide_hold", 8'h05, 1'b0);

      setUpd(4'd1, 2'b00, 32'h7F, 32'h01, 32'h80);
      applyStimulus("rst_inflight", 8'h05, 1'b1);
      nRst = 1; applyStimulus("rst_kill", 8'h00, 1'b0);
      applyStimulus("rst_nocommit", 8'h00, 1'b0);

      setWr(2'b00, 8'h0A); applyStimulus("move0A", 8'h0A, 1'b0);
      setUpd(4'd9, 2'b00, 32'h0, 32'h0, 32'h0); nBcd = 1;
      applyStimulus("bcd_pend", 8'h0A, 1'b1);
`ifdef CCR_BCD_EN
      applyStimulus("bcd_commit", 8'h1B, 1'b0);
      setWr(2'b00, 8'h0A); applyStimulus("move0A_b", 8'h0A, 1'b0);
`else
      applyStimulus("bcd_reserved", 8'h0A, 1'b0);
`endif
      setUpd(4'd12, 2'b10, 32'h0, 32'h0, 32'h0);
      applyStimulus("rsvd_pend", 8'h0A, 1'b1);
      setUpd(4'd0, 2'b10, 32'h0, 32'h0, 32'h0);
      applyStimulus("rsvd_commit", 8'h0A, 1'b1);
      applyStimulus("none_commit", 8'h0A, 1'b0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #3;
      if (sb.size() != 0) begin
         checks++;
         $display("[TB] FAIL drain: got %0d entries left expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
